// File: rtl/suma_pf_pipe.sv
// suma_pf_pipe: multi-cycle floating-point adder/subtractor.
// It works on one operation at a time and walks through IDLE, ALIGN, ADD,
// NORM, ROUND and DONE. Operands with a zero exponent are flushed to zero.
// Rounding is round-to-nearest-even.
module suma_pf_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic                r_op;
    logic                r_sign;
    logic                r_subtract;
    logic                r_zeroSign;
    logic                r_isZero;
    logic [EW-1:0]       r_exp;
    logic [MW-1:0]       r_manL;
    logic [MW-1:0]       r_manS;
    logic [MW:0]         r_sum;
    logic [MW-1:0]       r_man;
    logic                r_spec;
    logic [W-1:0]        r_specRes;
    logic [3:0]          r_specFlags;
    logic [W-1:0]        r_result;
    logic [3:0]          r_flags;

    // Leading-zero count; the highest set bit wins because it is visited last.
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) lzc = LZW'(MW - 1 - i);
        end
    endfunction

    // Operand decode, done while in ALIGN
    logic               w_sA, w_sB;
    logic [EXP_W-1:0]   w_eA, w_eB, w_eL, w_eS, w_diff;
    logic [MAN_W-1:0]   w_fA, w_fB;
    logic               w_zeroA, w_zeroB, w_nanA, w_nanB, w_infA, w_infB;
    logic               w_nan, w_inf, w_infSign, w_aBig;
    logic [W-2:0]       w_magA, w_magB;
    logic [MW-1:0]      w_extA, w_extB, w_mL, w_mS, w_shifted, w_mSal;
    logic               w_lost;
    logic [31:0]        w_diff32;

    assign w_sA    = r_a[W-1];
    assign w_sB    = r_b[W-1] ^ r_op;
    assign w_eA    = r_a[W-2:MAN_W];
    assign w_eB    = r_b[W-2:MAN_W];
    assign w_fA    = r_a[MAN_W-1:0];
    assign w_fB    = r_b[MAN_W-1:0];
    assign w_zeroA = (w_eA == '0);
    assign w_zeroB = (w_eB == '0);
    assign w_nanA  = (w_eA == EXP_ONES) && (w_fA != '0);
    assign w_nanB  = (w_eB == EXP_ONES) && (w_fB != '0);
    assign w_infA  = (w_eA == EXP_ONES) && (w_fA == '0);
    assign w_infB  = (w_eB == EXP_ONES) && (w_fB == '0);
    assign w_nan   = w_nanA | w_nanB | (w_infA & w_infB & (w_sA ^ w_sB));
    assign w_inf   = w_infA | w_infB;
    assign w_infSign = w_infA ? w_sA : w_sB;
    assign w_magA  = w_zeroA ? '0 : r_a[W-2:0];
    assign w_magB  = w_zeroB ? '0 : r_b[W-2:0];
    assign w_aBig  = (w_magA >= w_magB);
    assign w_extA  = w_zeroA ? '0 : {1'b1, w_fA, 3'b000};
    assign w_extB  = w_zeroB ? '0 : {1'b1, w_fB, 3'b000};
    assign w_eL    = w_aBig ? w_eA : w_eB;
    assign w_eS    = w_aBig ? w_eB : w_eA;
    assign w_mL    = w_aBig ? w_extA : w_extB;
    assign w_mS    = w_aBig ? w_extB : w_extA;
    assign w_diff  = w_eL - w_eS;
    assign w_diff32  = {{(32-EXP_W){1'b0}}, w_diff};
    assign w_shifted = w_mS >> w_diff;
    assign w_lost    = |(w_mS & ~({MW{1'b1}} << w_diff));
    assign w_mSal    = (w_diff32 >= 32'(MAN_W + 3)) ? {{(MW-1){1'b0}}, |w_mS}
                                                    : {w_shifted[MW-1:1], w_shifted[0] | w_lost};

    // Normalisation: carry-out shifts right, otherwise shift left by leading zeros
    logic [LZW-1:0] w_lz;
    logic [MW-1:0]  w_normMan;
    logic [EW-1:0]  w_normExp;

    assign w_lz      = lzc(r_sum[MW-1:0]);
    assign w_normMan = r_sum[MW] ? {r_sum[MW:2], r_sum[1] | r_sum[0]} : (r_sum[MW-1:0] << w_lz);
    assign w_normExp = r_sum[MW] ? (r_exp + EW'(1)) : (r_exp - EW'(w_lz));

    // Rounding to nearest even using guard/round/sticky
    logic                w_up, w_inexact;
    logic [MAN_W+1:0]    w_rnd;
    logic [EW-1:0]       w_rExp;
    logic [MAN_W-1:0]    w_rFrac;
    logic [W-1:0]        w_res;
    logic [3:0]          w_flg;

    assign w_up      = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
    assign w_inexact = |r_man[2:0];
    assign w_rnd     = {1'b0, r_man[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_rExp    = r_exp + EW'(w_rnd[MAN_W+1]);
    assign w_rFrac   = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

    // Final result selection: specials, exact zero, overflow, underflow, normal
    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (r_spec) begin
            w_res = r_specRes;
            w_flg = r_specFlags;
        end else if (r_isZero) begin
            w_res = {r_zeroSign, {(W-1){1'b0}}};
        end else if ($signed(w_rExp) >= $signed(EXP_MAX)) begin
            w_res = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else if ($signed(w_rExp) < $signed(EW'(1))) begin
            w_res = {r_sign, {(W-1){1'b0}}};
            w_flg = 4'b0011;
        end else begin
            w_res = {r_sign, w_rExp[EXP_W-1:0], w_rFrac};
            w_flg = {3'b000, w_inexact};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: one state per cycle, waiting only in IDLE and DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ALIGN;
            ALIGN:   w_next = ADD;
            ADD:     w_next = NORM;
            NORM:    w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        result    = r_result;
        flags     = r_flags;
    end

    // Datapath registers, advanced by the stage the FSM is in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_op <= 1'b0;
            r_sign <= 1'b0; r_subtract <= 1'b0; r_zeroSign <= 1'b0; r_isZero <= 1'b0;
            r_exp <= '0; r_manL <= '0; r_manS <= '0; r_sum <= '0; r_man <= '0;
            r_spec <= 1'b0; r_specRes <= '0; r_specFlags <= '0;
            r_result <= '0; r_flags <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_op <= op;
                end
                ALIGN: begin
                    r_sign      <= w_aBig ? w_sA : w_sB;
                    r_subtract  <= w_sA ^ w_sB;
                    r_zeroSign  <= w_sA & w_sB;
                    r_exp       <= {2'b00, w_eL};
                    r_manL      <= w_mL;
                    r_manS      <= w_mSal;
                    r_spec      <= w_nan | w_inf;
                    r_specRes   <= w_nan ? QNAN : {w_infSign, EXP_ONES, {MAN_W{1'b0}}};
                    r_specFlags <= w_nan ? 4'b1000 : 4'b0000;
                end
                ADD: begin
                    r_sum <= r_subtract ? ({1'b0, r_manL} - {1'b0, r_manS})
                                        : ({1'b0, r_manL} + {1'b0, r_manS});
                end
                NORM: begin
                    r_man    <= w_normMan;
                    r_exp    <= w_normExp;
                    r_isZero <= (r_sum == '0);
                end
                ROUND: begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_suma_pf_pipe.sv
// tb_suma_pf_pipe: directed scoreboard bench for suma_pf_pipe.
// The bench uses a single-precision instance and a half-precision instance.
module tb_suma_pf_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } expect_t;
    expect_t sbq[$];

    suma_pf_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    suma_pf_pipe #(.EXP_W(5), .MAN_W(10)) dutHalf (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                                 input logic [31:0] eres, input logic [3:0] eflg, input bit push);
        expect_t e;
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        a = va; b = vb; op = vop; in_valid = 1'b1;
        if (push) begin
            e.res = eres;
            e.flg = eflg;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int holdCycles);
        expect_t e;
        int lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_latency"}, lat, 32'd5);
        compared++;
        assert (sbq.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL %s_scoreboard: observed empty queue, required an entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_flags"}, {28'b0, flags}, {28'b0, e.flg});
            if (holdCycles > 0) begin
                in_valid = 1'b1; a = 32'h4120_0000; b = 32'h3F80_0000; op = 1'b0;
            end
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
                check({tag, "_hold_result"}, result, e.res);
                check({tag, "_hold_flags"}, {28'b0, flags}, {28'b0, e.flg});
                check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_release_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    // Directed sequence
    initial begin
        bit sawValid;
        int lat;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; op = 1'b0;
        a = 32'h3F80_0000; b = 32'h3F80_0000;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_op = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {28'b0, flags}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("post_reset_no_capture", {31'b0, in_ready}, 32'd1);

        applyStimulus(32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 4'b0000, 1'b1);
        checkOutput("add_1p5_2p5", 0);
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b1);
        checkOutput("sub_equal", 0);
        applyStimulus(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001, 1'b1);
        checkOutput("tie_even", 0);
        applyStimulus(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 4'b0001, 1'b1);
        checkOutput("round_up", 0);
        applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101, 1'b1);
        checkOutput("overflow", 0);
        applyStimulus(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000, 1'b1);
        checkOutput("inf_minus_inf", 0);
        applyStimulus(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000, 1'b1);
        checkOutput("nan_in", 0);
        applyStimulus(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 4'b0000, 1'b1);
        checkOutput("inf_pass", 0);
        applyStimulus(32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 4'b0000, 1'b1);
        checkOutput("neg_plus_pos", 0);
        applyStimulus(32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 4'b0000, 1'b1);
        checkOutput("sub_negative", 0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000, 1'b1);
        checkOutput("neg_zero", 0);
        applyStimulus(32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'b0011, 1'b1);
        checkOutput("underflow", 0);

        applyStimulus(32'h3F80_0000, 32'h3F00_0000, 1'b1, 32'h3F00_0000, 4'b0000, 1'b1);
        checkOutput("stall", 10);
        sawValid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) sawValid = 1'b1;
        end
        check("stall_no_stray_capture", {31'b0, sawValid}, 32'd0);

        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0, 4'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h4040_0000, 4'b0000, 1'b1);
        checkOutput("after_abort", 0);

        h_a = 16'h3C00; h_b = 16'h3C00; h_op = 1'b0; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (h_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("half_add_latency", lat, 32'd5);
        check("half_add_result", {16'b0, h_result}, 32'h0000_4000);
        check("half_add_flags", {28'b0, h_flags}, 32'd0);
        @(posedge clk); #1;
        h_a = 16'h3C00; h_b = 16'h3800; h_op = 1'b1; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (h_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("half_sub_latency", lat, 32'd5);
        check("half_sub_result", {16'b0, h_result}, 32'h0000_3800);
        check("half_sub_flags", {28'b0, h_flags}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
